// File: rtl/fano_pkg.sv
// rtl/fano_pkg.sv - rib width, default code generators, encoder states and parity helper
package fano_pkg;

    localparam int RIB_W = 2;

    // Default K=7 code; rib bit 1 comes from G0 and rib bit 0 from G1.
    localparam int         K_DEF  = 7;
    localparam logic [6:0] G0_DEF = 7'b1001111;
    localparam logic [6:0] G1_DEF = 7'b1101101;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } enc_state_t;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// rtl/conv_encoder_if.sv - information-bit input and code-rib output handshakes
interface conv_encoder_if;
    import fano_pkg::*;

    logic             i_vld;
    logic             i_bit;
    logic             i_last;
    logic             o_rdy;
    logic             o_vld;
    logic [RIB_W-1:0] o_rib;
    logic             o_last;
    logic             i_rdy;

    modport slave (
        input  i_vld, i_bit, i_last, i_rdy,
        output o_rdy, o_vld, o_rib, o_last
    );

    modport master (
        output i_vld, i_bit, i_last, i_rdy,
        input  o_rdy, o_vld, o_rib, o_last
    );

endinterface

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 feed-forward convolutional encoder with optional zero tail
module conv_encoder
    import fano_pkg::*;
#(
    parameter int          K       = K_DEF,
    parameter logic [K-1:0] G0     = K'(G0_DEF),
    parameter logic [K-1:0] G1     = K'(G1_DEF),
    parameter bit          TAIL_EN = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    conv_encoder_if.slave bus
);

    localparam int CW = $clog2(K);

    enc_state_t       state_q, state_d;
    logic [K-2:0]     sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [RIB_W-1:0] rib_q, rib_d;
    logic             last_q, last_d;

    logic             free;
    logic             rdy;
    logic             step;
    logic             in_bit;
    logic             clr_sr;
    logic             last_n;
    logic [K-1:0]     win;

    // The output register is the only storage stage, so every advance waits on it.
    assign free = !vld_q || bus.i_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DATA;
            sr_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            rib_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            rib_q   <= rib_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        rib_d   = rib_q;
        last_d  = last_q;
        rdy     = 1'b0;
        step    = 1'b0;
        in_bit  = 1'b0;
        clr_sr  = 1'b0;
        last_n  = 1'b0;

        case (state_q)
            ST_DATA: begin
                rdy = free;
                if (bus.i_vld && free) begin
                    step   = 1'b1;
                    in_bit = bus.i_bit;
                    if (bus.i_last) begin
                        if (TAIL_EN) begin
                            state_d = ST_TAIL;
                            cnt_d   = CW'(K - 1);
                        end else begin
                            last_n = 1'b1;
                            clr_sr = 1'b1;
                        end
                    end
                end
            end
            ST_TAIL: begin
                // Zero bits flush the memory; the final one also closes the frame.
                if (free) begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        last_n  = 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase

        win = {sr_q, in_bit};

        if (step) begin
            vld_d  = 1'b1;
            rib_d  = {parity(32'(win & G0)), parity(32'(win & G1))};
            last_d = last_n;
            sr_d   = clr_sr ? '0 : win[K-2:0];
        end else if (free) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    assign bus.o_rdy  = rdy;
    assign bus.o_vld  = vld_q;
    assign bus.o_rib  = rib_q;
    assign bus.o_last = last_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - randomized self-checking bench for conv_encoder against a frame-level code model
module tb_conv_encoder;
    import fano_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_if if0 ();
    conv_encoder_if if1 ();
    conv_encoder_if if2 ();

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) u_enc0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) u_enc1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));
    conv_encoder #(.K(7), .G0(7'b1001111), .G1(7'b1101101), .TAIL_EN(1'b1)) u_enc2 (
        .clk(clk), .reset_n(reset_n), .bus(if2));

    int lane_k   [3] = '{3, 3, 7};
    int lane_g0  [3] = '{7, 7, 79};
    int lane_g1  [3] = '{5, 5, 109};
    int lane_tail[3] = '{1, 0, 1};

    int n_checks = 0;
    int n_errors = 0;

    logic       src_q[$];
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    int         mon_lane = 0;
    int         acc_cnt  = 0;
    int         rdy_low  = 0;
    bit         cnt_en   = 1'b0;
    bit         hold_v   = 1'b0;
    logic [2:0] hold_val = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int lane, input logic vld, input logic b, input logic last,
                          input logic rdy);
        case (lane)
            0: begin if0.i_vld = vld; if0.i_bit = b; if0.i_last = last; if0.i_rdy = rdy; end
            1: begin if1.i_vld = vld; if1.i_bit = b; if1.i_last = last; if1.i_rdy = rdy; end
            default: begin if2.i_vld = vld; if2.i_bit = b; if2.i_last = last; if2.i_rdy = rdy; end
        endcase
    endtask

    task automatic get_out(input int lane, output logic ordy, output logic ovld,
                           output logic [1:0] rib, output logic olast, output logic irdy,
                           output logic ivld);
        case (lane)
            0: begin ordy = if0.o_rdy; ovld = if0.o_vld; rib = if0.o_rib; olast = if0.o_last;
                     irdy = if0.i_rdy; ivld = if0.i_vld; end
            1: begin ordy = if1.o_rdy; ovld = if1.o_vld; rib = if1.o_rib; olast = if1.o_last;
                     irdy = if1.i_rdy; ivld = if1.i_vld; end
            default: begin ordy = if2.o_rdy; ovld = if2.o_vld; rib = if2.o_rib; olast = if2.o_last;
                     irdy = if2.i_rdy; ivld = if2.i_vld; end
        endcase
    endtask

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        logic m_ordy, m_ovld, m_olast, m_irdy, m_ivld;
        logic [1:0] m_rib;
        get_out(mon_lane, m_ordy, m_ovld, m_rib, m_olast, m_irdy, m_ivld);
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("stall_hold", {m_ovld, m_olast, m_rib}, {1'b1, hold_val});
            if (m_ovld && m_irdy) got_q.push_back({m_olast, m_rib});
            if (m_ivld && m_ordy) acc_cnt++;
            if (cnt_en && !m_ordy) rdy_low++;
            hold_v   = m_ovld && !m_irdy;
            hold_val = {m_olast, m_rib};
        end
    end

    // Reference: rib t is the generator-weighted parity of the frame bits t..t-K+1,
    // with zeros before the frame start and zeros appended as the tail.
    task automatic model(input int lane, input int n);
        int k  = lane_k[lane];
        int g0 = lane_g0[lane];
        int g1 = lane_g1[lane];
        int tl = lane_tail[lane] ? k - 1 : 0;
        for (int t = 0; t < n + tl; t++) begin
            logic c0, c1, xb;
            c0 = 1'b0;
            c1 = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (t - j >= 0 && t - j < n) begin
                    xb = src_q[t - j];
                    c0 = c0 ^ (xb & g0[j]);
                    c1 = c1 ^ (xb & g1[j]);
                end
            end
            exp_q.push_back({(t == n + tl - 1) ? 1'b1 : 1'b0, c0, c1});
        end
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, {29'd0, got_q[i]}, {29'd0, exp_q[i]});
    endtask

    task automatic fill_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(1'($urandom_range(1)));
    endtask

    task automatic run_frame(input int lane, input int n, input int stall, input bit hold);
        int   idx   = 0;
        int   guard = 0;
        bit   done  = 1'b0;
        logic ordy, ovld, olast, irdy, ivld;
        logic [1:0] rib;
        acc_cnt = 0;
        while (idx < n && guard < 4000) begin
            @(posedge clk); #1;
            set_in(lane, 1'b1, src_q[idx], idx == n - 1, $urandom_range(99) >= stall);
            @(negedge clk);
            get_out(lane, ordy, ovld, rib, olast, irdy, ivld);
            if (ordy) idx++;
            guard++;
        end
        // Keep i_vld up with junk bits until the final rib leaves the register.
        while (!done && guard < 4000) begin
            @(posedge clk); #1;
            get_out(lane, ordy, ovld, rib, olast, irdy, ivld);
            set_in(lane, hold && !(ovld && olast), 1'($urandom_range(1)), 1'b0,
                   $urandom_range(99) >= stall);
            @(negedge clk);
            get_out(lane, ordy, ovld, rib, olast, irdy, ivld);
            if (ovld && irdy && olast) done = 1'b1;
            guard++;
        end
        @(posedge clk); #1;
        set_in(lane, 1'b0, 1'b0, 1'b0, 1'b1);
        check("timeout", {31'd0, guard >= 4000}, 32'd0);
        check("accepted", acc_cnt, n);
    endtask

    task automatic scenario_basic(input string tag);
        mon_lane = 0;
        got_q.delete();
        src_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        rdy_low = 0;
        cnt_en  = 1'b1;
        run_frame(0, 4, 0, 1'b1);
        cnt_en  = 1'b0;
        compare_q(tag);
        check({tag, "_rdy_low"}, rdy_low, 2);
    endtask

    initial begin
        logic ordy, ovld, olast, irdy, ivld;
        logic [1:0] rib;
        for (int l = 0; l < 3; l++) set_in(l, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        for (int l = 0; l < 3; l++) begin
            get_out(l, ordy, ovld, rib, olast, irdy, ivld);
            check("reset_out", {ovld, olast, rib}, 4'b0000);
        end
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        get_out(0, ordy, ovld, rib, olast, irdy, ivld);
        check("idle_rdy", {31'd0, ordy}, 32'd1);

        scenario_basic("k3_tail");

        mon_lane = 1;
        got_q.delete();
        src_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        run_frame(1, 4, 0, 1'b0);
        src_q = '{1'b1};
        run_frame(1, 1, 0, 1'b0);
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b101, 3'b111};
        compare_q("k3_notail");

        mon_lane = 2;
        got_q.delete();
        exp_q.delete();
        fill_src(100);
        model(2, 100);
        run_frame(2, 100, 50, 1'b1);
        compare_q("k7_stall");

        mon_lane = 0;
        got_q.delete();
        exp_q.delete();
        fill_src(20);
        model(0, 20);
        run_frame(0, 20, 30, 1'b1);
        fill_src(5);
        model(0, 5);
        run_frame(0, 5, 0, 1'b1);
        compare_q("k3_two_frames");

        mon_lane = 1;
        got_q.delete();
        exp_q.delete();
        fill_src(30);
        model(1, 30);
        run_frame(1, 30, 40, 1'b0);
        fill_src(1);
        model(1, 1);
        run_frame(1, 1, 0, 1'b0);
        compare_q("k3_notail_rand");

        // Mid-frame reset, asserted between clock edges while a rib is stalled.
        mon_lane = 0;
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        get_out(0, ordy, ovld, rib, olast, irdy, ivld);
        check("pre_reset_vld", {31'd0, ovld}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        get_out(0, ordy, ovld, rib, olast, irdy, ivld);
        check("async_reset", {ovld, olast, rib}, 4'b0000);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(negedge clk);
        get_out(0, ordy, ovld, rib, olast, irdy, ivld);
        check("post_reset_rdy", {31'd0, ordy}, 32'd1);
        scenario_basic("after_reset");

        mon_lane = 2;
        got_q.delete();
        exp_q.delete();
        fill_src(64);
        model(2, 64);
        run_frame(2, 64, 0, 1'b1);
        compare_q("k7_64");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
